// File: rtl/sd_play_sched_if.sv
// Reader handshake between the playback scheduler (master) and the SD frame reader (slave).
interface sd_play_sched_if;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_busy;
  logic        rd_done;

  modport master (output rd_req, rd_addr, input rd_busy, rd_done);
  modport slave  (input rd_req, rd_addr, output rd_busy, rd_done);
endinterface

// File: rtl/sd_play_sched.sv
// SD clip playback scheduler: paces one frame read per display tick and tracks position.
// Define SD_PLAY_LOOP_EN to wrap to the first frame at end of clip instead of stopping in DONE.
module sd_play_sched #(
  parameter int unsigned FRAME_W  = 8,
  parameter int unsigned WDOG_CYC = 5000000
) (
  input  logic               HCLK,
  input  logic               HRESET,
  input  logic               init_end,
  input  logic               frame_tick,
  input  logic               play,
  input  logic               pause,
  input  logic               rewind,
  input  logic [31:0]        base_addr,
  input  logic [15:0]        sect_per_frame,
  input  logic [FRAME_W-1:0] frame_total,
  sd_play_sched_if.master    rd,
  output logic [FRAME_W-1:0] frame_idx,
  output logic [2:0]         state,
  output logic               playing,
  output logic               underrun,
  output logic               timeout
);

  localparam int unsigned     WD_W   = (WDOG_CYC > 2) ? $clog2(WDOG_CYC) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(WDOG_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_STOP      = 3'd1,
    S_WAIT_TICK = 3'd2,
    S_ISSUE     = 3'd3,
    S_READING   = 3'd4,
    S_PAUSED    = 3'd5,
    S_DONE      = 3'd6,
    S_ERR       = 3'd7
  } state_e;

  state_e             state_q, state_d;
  logic               rd_req_q, rd_req_d;
  logic [31:0]        rd_addr_q, rd_addr_d;
  logic [FRAME_W-1:0] frame_idx_q, frame_idx_d;
  logic               playing_q, playing_d;
  logic               underrun_q, underrun_d;
  logic               timeout_q, timeout_d;
  logic               pend_q, pend_d;
  logic               pause_lat_q, pause_lat_d;
  logic               rew_lat_q, rew_lat_d;
  logic [WD_W-1:0]    wdog_q, wdog_d;
  logic [31:0]        base_q, base_d;
  logic [15:0]        spf_q, spf_d;
  logic [FRAME_W-1:0] total_q, total_d;

  logic cfg_load;
  logic queue_tick;
  logic do_rewind;
  logic last_frame;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d     = state_q;
    rd_req_d    = 1'b0;
    rd_addr_d   = rd_addr_q;
    frame_idx_d = frame_idx_q;
    underrun_d  = underrun_q;
    timeout_d   = timeout_q;
    pend_d      = pend_q;
    pause_lat_d = pause_lat_q;
    rew_lat_d   = rew_lat_q;
    wdog_d      = wdog_q;
    queue_tick  = 1'b0;
    do_rewind   = 1'b0;

    // Clip geometry is only allowed to change while the player is stopped.
    cfg_load   = (state_q == S_IDLE) || (state_q == S_STOP);
    base_d     = cfg_load ? base_addr      : base_q;
    spf_d      = cfg_load ? sect_per_frame : spf_q;
    total_d    = cfg_load ? frame_total    : total_q;
    last_frame = (frame_idx_q == total_q - FRAME_W'(1));

    if (!init_end && (state_q != S_IDLE) && (state_q != S_ERR)) begin
      state_d     = S_IDLE;
      pend_d      = 1'b0;
      pause_lat_d = 1'b0;
      rew_lat_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (init_end) state_d = S_STOP;
        S_STOP: begin
          if (rewind) do_rewind = 1'b1;
          else if (play) begin
            state_d     = S_WAIT_TICK;
            rd_addr_d   = base_d;
            frame_idx_d = '0;
          end
        end
        S_WAIT_TICK: begin
          if (rewind) do_rewind = 1'b1;
          else if (pause) state_d = S_PAUSED;
          else if ((frame_tick || pend_q) && !rd.rd_busy) begin
            state_d = S_ISSUE;
            pend_d  = 1'b0;
          end else queue_tick = frame_tick;
        end
        S_ISSUE: begin
          rd_req_d   = 1'b1;
          wdog_d     = '0;
          state_d    = S_READING;
          queue_tick = frame_tick;
          if (rewind) rew_lat_d = 1'b1;
          if (pause) pause_lat_d = 1'b1;
        end
        S_READING: begin
          queue_tick = frame_tick;
          if (rewind) rew_lat_d = 1'b1;
          if (pause) pause_lat_d = 1'b1;
          if (rd.rd_done) begin
            pause_lat_d = 1'b0;
            // A rewind requested mid-read swallows this completion instead of advancing.
            if (rew_lat_q || rewind) do_rewind = 1'b1;
            else begin
              rd_addr_d   = rd_addr_q + 32'(spf_q);
              frame_idx_d = frame_idx_q + FRAME_W'(1);
              state_d     = (pause_lat_q || pause) ? S_PAUSED : S_WAIT_TICK;
              if (last_frame) begin
`ifdef SD_PLAY_LOOP_EN
                rd_addr_d   = base_q;
                frame_idx_d = '0;
`else
                state_d     = S_DONE;
`endif
              end
            end
          end else if (wdog_q == WD_MAX) begin
            timeout_d = 1'b1;
            state_d   = S_ERR;
          end else wdog_d = wdog_q + WD_W'(1);
        end
        S_PAUSED: begin
          if (rewind) do_rewind = 1'b1;
          else if (play) state_d = S_WAIT_TICK;
        end
        S_DONE: if (rewind) do_rewind = 1'b1;
        S_ERR:  ;
      endcase
    end

    // One tick may wait for the reader; a second one overruns and is dropped.
    if (queue_tick) begin
      if (pend_q) underrun_d = 1'b1;
      else        pend_d     = 1'b1;
    end

    if (do_rewind) begin
      state_d     = S_STOP;
      rd_addr_d   = base_d;
      frame_idx_d = '0;
      pend_d      = 1'b0;
      pause_lat_d = 1'b0;
      rew_lat_d   = 1'b0;
    end

    playing_d = (state_d == S_WAIT_TICK) || (state_d == S_ISSUE) || (state_d == S_READING);
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= S_IDLE;
      rd_req_q    <= 1'b0;
      rd_addr_q   <= '0;
      frame_idx_q <= '0;
      playing_q   <= 1'b0;
      underrun_q  <= 1'b0;
      timeout_q   <= 1'b0;
      pend_q      <= 1'b0;
      pause_lat_q <= 1'b0;
      rew_lat_q   <= 1'b0;
      wdog_q      <= '0;
      base_q      <= '0;
      spf_q       <= '0;
      total_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      rd_req_q    <= rd_req_d;
      rd_addr_q   <= rd_addr_d;
      frame_idx_q <= frame_idx_d;
      playing_q   <= playing_d;
      underrun_q  <= underrun_d;
      timeout_q   <= timeout_d;
      pend_q      <= pend_d;
      pause_lat_q <= pause_lat_d;
      rew_lat_q   <= rew_lat_d;
      wdog_q      <= wdog_d;
      base_q      <= base_d;
      spf_q       <= spf_d;
      total_q     <= total_d;
    end
  end

  assign rd.rd_req  = rd_req_q;
  assign rd.rd_addr = rd_addr_q;
  assign frame_idx  = frame_idx_q;
  assign state      = state_q;
  assign playing    = playing_q;
  assign underrun   = underrun_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_sd_play_sched.sv
// Directed bench for sd_play_sched: per-cycle vector table plus reset, watchdog and abort sequences.
module tb_sd_play_sched;

  localparam logic [6:0] KI = 7'h01;  // init_end
  localparam logic [6:0] KT = 7'h02;  // frame_tick
  localparam logic [6:0] KP = 7'h04;  // play
  localparam logic [6:0] KZ = 7'h08;  // pause
  localparam logic [6:0] KR = 7'h10;  // rewind
  localparam logic [6:0] KD = 7'h20;  // rd_done
  localparam logic [6:0] KB = 7'h40;  // rd_busy

  localparam logic [2:0] FP = 3'b100;  // playing
  localparam logic [2:0] FU = 3'b010;  // underrun

  localparam logic [31:0] BASE = 32'd34880;
  localparam logic [31:0] A1   = 32'd35180;
  localparam logic [31:0] A2   = 32'd35480;

  typedef struct {
    logic [6:0]  cmd;
    logic [2:0]  st;
    logic        req;
    logic [31:0] addr;
    logic [7:0]  idx;
    logic [2:0]  fl;
    bit          care_ai;
  } vec_t;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        init_end, frame_tick, play, pause, rewind;
  logic [31:0] base_addr;
  logic [15:0] sect_per_frame;
  logic [7:0]  frame_total;
  logic [7:0]  frame_idx;
  logic [2:0]  state;
  logic        playing, underrun, timeout;

  int n_vec = 0;
  int n_bad = 0;
  vec_t tbl[$];

  sd_play_sched_if rd_if ();

  sd_play_sched #(.FRAME_W(8), .WDOG_CYC(100)) dut (
    .HCLK           (HCLK),
    .HRESET         (HRESET),
    .init_end       (init_end),
    .frame_tick     (frame_tick),
    .play           (play),
    .pause          (pause),
    .rewind         (rewind),
    .base_addr      (base_addr),
    .sect_per_frame (sect_per_frame),
    .frame_total    (frame_total),
    .rd             (rd_if.master),
    .frame_idx      (frame_idx),
    .state          (state),
    .playing        (playing),
    .underrun       (underrun),
    .timeout        (timeout)
  );

  always #5 HCLK = ~HCLK;

  function automatic vec_t mk(input logic [6:0] cmd, input logic [2:0] st, input logic req,
                              input logic [31:0] addr, input logic [7:0] idx, input logic [2:0] fl,
                              input bit care_ai = 1'b1);
    vec_t v;
    v.cmd = cmd; v.st = st; v.req = req; v.addr = addr; v.idx = idx; v.fl = fl; v.care_ai = care_ai;
    return v;
  endfunction

  task automatic drive(input logic [6:0] c);
    init_end      = c[0];
    frame_tick    = c[1];
    play          = c[2];
    pause         = c[3];
    rewind        = c[4];
    rd_if.rd_done = c[5];
    rd_if.rd_busy = c[6];
  endtask

  task automatic step(input logic [6:0] c);
    @(negedge HCLK);
    drive(c);
    @(posedge HCLK);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input int n, input vec_t x);
    logic bad;
    bad = (state !== x.st) || (rd_if.rd_req !== x.req) || ({playing, underrun, timeout} !== x.fl) ||
          (x.care_ai && ((rd_if.rd_addr !== x.addr) || (frame_idx !== x.idx)));
    n_vec++;
    if (bad) begin
      n_bad++;
      $display("FAIL vec%0d: got st=%0d req=%0d addr=%0d idx=%0d flags=%b, expected st=%0d req=%0d addr=%0d idx=%0d flags=%b",
               n, state, rd_if.rd_req, rd_if.rd_addr, frame_idx, {playing, underrun, timeout},
               x.st, x.req, x.addr, x.idx, x.fl);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int req_seen;
    base_addr      = BASE;
    sect_per_frame = 16'd300;
    frame_total    = 8'd3;

    // Play through the clip: one read per tick, address advances by 300 sectors.
    tbl.push_back(mk(KI|KP, 3'd2, 1'b0, BASE, 8'd0, FP));
    tbl.push_back(mk(KI|KT, 3'd3, 1'b0, BASE, 8'd0, FP));
    tbl.push_back(mk(KI,    3'd4, 1'b1, BASE, 8'd0, FP));
    tbl.push_back(mk(KI,    3'd4, 1'b0, BASE, 8'd0, FP));
    tbl.push_back(mk(KI|KD, 3'd2, 1'b0, A1,   8'd1, FP));
    tbl.push_back(mk(KI|KT, 3'd3, 1'b0, A1,   8'd1, FP));
    tbl.push_back(mk(KI,    3'd4, 1'b1, A1,   8'd1, FP));
    tbl.push_back(mk(KI|KD, 3'd2, 1'b0, A2,   8'd2, FP));
    tbl.push_back(mk(KI|KT, 3'd3, 1'b0, A2,   8'd2, FP));
    tbl.push_back(mk(KI,    3'd4, 1'b1, A2,   8'd2, FP));
`ifdef SD_PLAY_LOOP_EN
    tbl.push_back(mk(KI|KD, 3'd2, 1'b0, BASE, 8'd0, FP));
    tbl.push_back(mk(KI|KT, 3'd3, 1'b0, BASE, 8'd0, FP));
    tbl.push_back(mk(KI,    3'd4, 1'b1, BASE, 8'd0, FP));
    tbl.push_back(mk(KI|KR, 3'd4, 1'b0, BASE, 8'd0, FP));
    tbl.push_back(mk(KI|KD, 3'd1, 1'b0, BASE, 8'd0, 3'b000));
`else
    tbl.push_back(mk(KI|KD, 3'd6, 1'b0, BASE, 8'd0, 3'b000, 1'b0));
    tbl.push_back(mk(KI|KT, 3'd6, 1'b0, BASE, 8'd0, 3'b000, 1'b0));
    tbl.push_back(mk(KI|KP, 3'd6, 1'b0, BASE, 8'd0, 3'b000, 1'b0));
    tbl.push_back(mk(KI|KR, 3'd1, 1'b0, BASE, 8'd0, 3'b000));
    tbl.push_back(mk(KI,    3'd1, 1'b0, BASE, 8'd0, 3'b000));
`endif
    // Three ticks in one read: underrun, then exactly one catch-up request.
    tbl.push_back(mk(KI|KP, 3'd2, 1'b0, BASE, 8'd0, FP));
    tbl.push_back(mk(KI|KT, 3'd3, 1'b0, BASE, 8'd0, FP));
    tbl.push_back(mk(KI,    3'd4, 1'b1, BASE, 8'd0, FP));
    tbl.push_back(mk(KI|KT, 3'd4, 1'b0, BASE, 8'd0, FP));
    tbl.push_back(mk(KI|KT, 3'd4, 1'b0, BASE, 8'd0, FP|FU));
    tbl.push_back(mk(KI|KT, 3'd4, 1'b0, BASE, 8'd0, FP|FU));
    tbl.push_back(mk(KI|KD, 3'd2, 1'b0, A1,   8'd1, FP|FU));
    tbl.push_back(mk(KI,    3'd3, 1'b0, A1,   8'd1, FP|FU));
    tbl.push_back(mk(KI,    3'd4, 1'b1, A1,   8'd1, FP|FU));
    tbl.push_back(mk(KI,    3'd4, 1'b0, A1,   8'd1, FP|FU));
    tbl.push_back(mk(KI|KD, 3'd2, 1'b0, A2,   8'd2, FP|FU));
    tbl.push_back(mk(KI,    3'd2, 1'b0, A2,   8'd2, FP|FU));
    tbl.push_back(mk(KI,    3'd2, 1'b0, A2,   8'd2, FP|FU));
    tbl.push_back(mk(KI|KR, 3'd1, 1'b0, BASE, 8'd0, FU));
    // Pause, ignored ticks and stray rd_done, latched pause, coincident commands.
    tbl.push_back(mk(KI|KP,       3'd2, 1'b0, BASE, 8'd0, FP|FU));
    tbl.push_back(mk(KI|KZ,       3'd5, 1'b0, BASE, 8'd0, FU));
    tbl.push_back(mk(KI|KT,       3'd5, 1'b0, BASE, 8'd0, FU));
    tbl.push_back(mk(KI|KP,       3'd2, 1'b0, BASE, 8'd0, FP|FU));
    tbl.push_back(mk(KI|KD,       3'd2, 1'b0, BASE, 8'd0, FP|FU));
    tbl.push_back(mk(KI|KT,       3'd3, 1'b0, BASE, 8'd0, FP|FU));
    tbl.push_back(mk(KI|KZ,       3'd4, 1'b1, BASE, 8'd0, FP|FU));
    tbl.push_back(mk(KI|KD,       3'd5, 1'b0, A1,   8'd1, FU));
    tbl.push_back(mk(KI|KP,       3'd2, 1'b0, A1,   8'd1, FP|FU));
    tbl.push_back(mk(KI|KT,       3'd3, 1'b0, A1,   8'd1, FP|FU));
    tbl.push_back(mk(KI,          3'd4, 1'b1, A1,   8'd1, FP|FU));
    tbl.push_back(mk(KI|KP|KZ|KR, 3'd4, 1'b0, A1,   8'd1, FP|FU));
    tbl.push_back(mk(KI|KD,       3'd1, 1'b0, BASE, 8'd0, FU));
    // Reader busy holds the tick as pending; init_end loss forces IDLE keeping flags.
    tbl.push_back(mk(KI|KP,    3'd2, 1'b0, BASE, 8'd0, FP|FU));
    tbl.push_back(mk(KI|KT|KB, 3'd2, 1'b0, BASE, 8'd0, FP|FU));
    tbl.push_back(mk(KI|KB,    3'd2, 1'b0, BASE, 8'd0, FP|FU));
    tbl.push_back(mk(KI,       3'd3, 1'b0, BASE, 8'd0, FP|FU));
    tbl.push_back(mk(KI,       3'd4, 1'b1, BASE, 8'd0, FP|FU));
    tbl.push_back(mk(KI|KD,    3'd2, 1'b0, A1,   8'd1, FP|FU));
    tbl.push_back(mk(7'h00,    3'd0, 1'b0, A1,   8'd1, FU, 1'b0));
    tbl.push_back(mk(7'h00,    3'd0, 1'b0, A1,   8'd1, FU, 1'b0));
    tbl.push_back(mk(KI,       3'd1, 1'b0, A1,   8'd1, FU, 1'b0));
    // Start a read that never completes.
    tbl.push_back(mk(KI|KP, 3'd2, 1'b0, BASE, 8'd0, FP|FU));
    tbl.push_back(mk(KI|KT, 3'd3, 1'b0, BASE, 8'd0, FP|FU));
    tbl.push_back(mk(KI,    3'd4, 1'b1, BASE, 8'd0, FP|FU));

    // Reset for three cycles, init_end arrives around cycle 10.
    HRESET = 1'b1;
    drive(7'h00);
    repeat (3) @(posedge HCLK);
    #1;
    check("rst_state", 64'(state), 64'd0);
    check("rst_outputs", {rd_if.rd_req, rd_if.rd_addr, frame_idx, playing, underrun, timeout}, 64'd0);
    @(negedge HCLK);
    HRESET = 1'b0;
    for (int c = 4; c < 10; c++) step(7'h00);
    check("idle_before_init", 64'(state), 64'd0);
    step(KI);
    check("stop_after_init", 64'(state), 64'd1);
    check("outputs_after_init", {rd_if.rd_req, rd_if.rd_addr, frame_idx, playing, underrun, timeout}, 64'd0);

    foreach (tbl[i]) begin
      step(tbl[i].cmd);
      check_vec(i, tbl[i]);
    end

    // Watchdog: ERR exactly 100 cycles after rd_req, then deaf to commands.
    repeat (99) step(KI);
    check("wdog_99_state", 64'(state), 64'd4);
    check("wdog_99_no_timeout", 64'(timeout), 64'd0);
    step(KI);
    check("wdog_100_state", 64'(state), 64'd7);
    check("wdog_100_timeout", 64'(timeout), 64'd1);
    step(KI|KP);
    check("err_ignores_play", 64'(state), 64'd7);
    step(KI|KR);
    check("err_ignores_rewind", 64'(state), 64'd7);

    // Reset leaves ERR and clears the sticky flags.
    @(negedge HCLK);
    HRESET = 1'b1;
    drive(KI);
    @(posedge HCLK);
    #1;
    check("err_reset_outputs", {5'(state), rd_if.rd_req, rd_if.rd_addr, frame_idx, playing, underrun, timeout}, 64'd0);
    @(negedge HCLK);
    HRESET = 1'b0;
    step(KI);
    step(KI|KP);
    step(KI|KT);
    step(KI);
    check("abort_read_started", {61'(state), 3'(rd_if.rd_req)}, {61'd4, 3'd1});

    // Reset mid-read abandons it: no further request, late rd_done ignored.
    @(negedge HCLK);
    HRESET = 1'b1;
    drive(KI);
    @(posedge HCLK);
    #1;
    check("abort_reset_state", {5'(state), rd_if.rd_req, playing, underrun, timeout}, 64'd0);
    @(negedge HCLK);
    HRESET = 1'b0;
    req_seen = 0;
    for (int c = 0; c < 6; c++) begin
      step(KI|KD);
      if (rd_if.rd_req === 1'b1) req_seen++;
    end
    check("abort_no_rd_req", 64'(req_seen), 64'd0);
    check("abort_state_stop", 64'(state), 64'd1);
    check("abort_idx_zero", 64'(frame_idx), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
